seq_decoder: RTL and testbench
==============================

// Module: seq_decoder
// PURPOSE
//  Registered, handshaked decode stage between fetch and execute. Decodes DP, LDR/STR and B exactly as the combinational Decoder does.
//  Adds block transfer (LDM/STM, op=2'b10 & funct[5]=0): expands one instruction into one micro-op per listed register, one per cycle.
//  Branch is op=2'b10 & funct[5]=1.
// PARAMETERS
//  NUM_REGS  16  width of register list instr[NUM_REGS-1:0]; lists are indexed 0..NUM_REGS-1
//  OFS_W     8   signed byte-offset width; must be >= $clog2(4*NUM_REGS)+2
// PORTS
//  clk             in   1      clock; single clock domain
//  reset           in   1      synchronous, active-high reset
//  in_valid        in   1      fetch presents instr
//  in_ready        out  1      stage accepts instr this cycle
//  instr           in   32     op=instr[27:26], funct=instr[25:20], rd=instr[15:12], rn=instr[19:16]
//  out_valid       out  1      micro-op on outputs is valid
//  out_ready       in   1      execute consumes micro-op
//  ctl             out  ctl_t  pcs,reg_w,mem_w,mem_to_reg,alu_src,reg_src,base_reg_write,no_write,swap,inv,flag_w,imm_src,result_src,alu_ctl
//  uop_reg         out  4      target register of block-transfer micro-op (rd for single ops)
//  uop_offset      out  OFS_W  signed byte offset from base for this micro-op (0 for single ops)
//  uop_wb_offset   out  OFS_W  signed base-writeback delta, valid when ctl.base_reg_write=1
//  uop_first       out  1      first micro-op of instruction
//  uop_last        out  1      last micro-op of instruction
// BEHAVIOUR
//  - Reset: out_valid=0, ctl='0, uop_*='0, state=IDLE. in_ready=1 from the first cycle after reset deasserts.
//  - in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  - Single op: outputs registered on accept, out_valid next cycle (latency 1). uop_first=uop_last=1.
//  - Hold: out_valid && !out_ready keeps all outputs stable; no uop dropped or duplicated.
//  - FSM IDLE->EXPAND on accepted LDM/STM with popcount(list)>=2.
//    Latch mask, n=popcount, P=funct[4], U=funct[3], W=funct[1], L=funct[0].
//  - EXPAND: on each out_ready, emit the lowest set bit of the remaining mask and clear it.
//    Return to IDLE when the last uop is issued.
//  - Offset of k-th uop (k=0..n-1), OFS_W two's complement: 4k + (U ? 0 : -4n) + (P==U ? 4 : 0).
//    Covers IA, IB, DA, DB.
//  - Block uop ctl: mem_w=~L, reg_w=L, mem_to_reg=L, result_src=L?2'b10:2'b00, alu_src=1, alu_ctl=3'b000.
//    pcs=L&&uop_reg==15.
//  - uop_last: base_reg_write=W, uop_wb_offset = U ? 4n : -4n. base_reg_write=0 on all other uops.
//  - n==1: single uop, no EXPAND entry. n==0: one NOP uop (no_write=1, reg_w=0, mem_w=0, first=last=1).
//  - Reset mid-EXPAND: abandons the instruction; out_valid=0 next cycle; no further uops.
// CONFIGURATION
//  DECODE_PERF_EN defined: adds outputs perf_instr[31:0] (accepts), perf_uop[31:0] (out_valid&&out_ready)
//    and perf_stall[31:0] (out_valid&&!out_ready). All clear on reset, wrap at 2^32.
//  DECODE_PERF_EN undefined: these ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  decode_pkg: ctl_t struct, state_t enum {IDLE,EXPAND}, ALU_ADD/SUB/AND/ORR/ADC.
//    Also RESULT_ALU/ RESULT_SHIFT/ RESULT_MEM and OP_DP/OP_MEM/OP_BR constants.
//  Existing Decoder instantiated unchanged for single-op ctl.
//  New sub-module reg_list_scan: combinational lowest-set-bit index, one-hot clear mask and popcount over NUM_REGS.
// TESTING
//  1. reset=1 two cycles, then 0 -> out_valid=0 during reset; in_ready=1 first cycle after release.
//  2. 0xE0821003 (ADD r1,r2,r3), out_ready=1 -> next cycle out_valid=1, alu_ctl=000, reg_w=1, uop_reg=1, first=last=1.
//  3. 0xE8B0800A (LDMIA r0!,{r1,r3,r15}) -> 3 uops: (r1,0), (r3,4), (r15,8, pcs=1, last=1).
//     Last uop: base_reg_write=1, wb_offset=12. in_ready=0 throughout.
//  4. 0xE92D0030 (STMDB sp!,{r4,r5}) -> (r4,0xF8), (r5,0xFC), mem_w=1, reg_w=0; last: wb_offset=0xF8.
//  5. Case 3 with out_ready=0 for 3 cycles after first uop -> uop (r1,0) held stable.
//     Then (r3,4), (r15,8) follow with no gap/dup. perf_stall=3 with DECODE_PERF_EN.
//  6. Case 3, reset asserted after first uop handshake -> out_valid=0 next cycle.
//     Then 0xE8900000 (empty list) -> single NOP uop, no_write=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and encodings for the sequencing decode stage.
package decode_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_ADC = 3'b100;

    localparam logic [1:0] RESULT_ALU   = 2'b00;
    localparam logic [1:0] RESULT_SHIFT = 2'b01;
    localparam logic [1:0] RESULT_MEM   = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    typedef struct packed {
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] reg_src;
        logic       base_reg_write;
        logic       no_write;
        logic       swap;
        logic       inv;
        logic [1:0] flag_w;
        logic [1:0] imm_src;
        logic [1:0] result_src;
        logic [2:0] alu_ctl;
    } ctl_t;

    // Control word for one load/store micro-op of a block transfer.
    function automatic ctl_t blk_ctl(input logic l, input logic to_pc, input logic wb);
        ctl_t c;
        c                = '0;
        c.mem_w          = ~l;
        c.reg_w          = l;
        c.mem_to_reg     = l;
        c.result_src     = l ? RESULT_MEM : RESULT_ALU;
        c.alu_src        = 1'b1;
        c.alu_ctl        = ALU_ADD;
        c.pcs            = l & to_pc;
        c.base_reg_write = wb;
        return c;
    endfunction

    function automatic ctl_t nop_ctl();
        ctl_t c;
        c          = '0;
        c.no_write = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/decoder.sv
// Combinational single-instruction decoder for DP, LDR/STR and B.
module decoder
    import decode_pkg::*;
(
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    output ctl_t       ctl
);

    logic alu_op;
    logic branch;

    // Main decode followed by the ALU sub-decode for data processing.
    always_comb begin
        ctl    = '0;
        alu_op = 1'b0;
        branch = 1'b0;
        case (op)
            OP_DP: begin
                ctl.reg_w   = 1'b1;
                ctl.alu_src = funct[5];
                alu_op      = 1'b1;
            end
            OP_MEM: begin
                ctl.alu_src = 1'b1;
                ctl.imm_src = 2'b01;
                if (funct[0]) begin
                    ctl.reg_w      = 1'b1;
                    ctl.mem_to_reg = 1'b1;
                    ctl.result_src = RESULT_MEM;
                end else begin
                    ctl.mem_w   = 1'b1;
                    ctl.reg_src = 2'b10;
                end
            end
            OP_BR: begin
                branch      = 1'b1;
                ctl.alu_src = 1'b1;
                ctl.imm_src = 2'b10;
                ctl.reg_src = 2'b01;
            end
            default: begin
                ctl.no_write = 1'b1;
            end
        endcase

        if (alu_op) begin
            case (funct[4:1])
                4'b0100: ctl.alu_ctl = ALU_ADD;
                4'b0010: ctl.alu_ctl = ALU_SUB;
                4'b0011: begin ctl.alu_ctl = ALU_SUB; ctl.swap = 1'b1; end
                4'b0000: ctl.alu_ctl = ALU_AND;
                4'b1110: begin ctl.alu_ctl = ALU_AND; ctl.inv = 1'b1; end
                4'b1100: ctl.alu_ctl = ALU_ORR;
                4'b0101: ctl.alu_ctl = ALU_ADC;
                4'b1010: begin ctl.alu_ctl = ALU_SUB; ctl.no_write = 1'b1; end
                4'b1101: begin ctl.alu_ctl = ALU_ADD; ctl.result_src = RESULT_SHIFT; end
                default: ctl.alu_ctl = ALU_ADD;
            endcase
            // Carry/overflow flags only make sense for arithmetic operations.
            ctl.flag_w[1] = funct[0];
            ctl.flag_w[0] = funct[0] && (ctl.alu_ctl == ALU_ADD || ctl.alu_ctl == ALU_SUB ||
                                         ctl.alu_ctl == ALU_ADC) && (ctl.result_src == RESULT_ALU);
        end else begin
            ctl.flag_w = 2'b00;
        end

        ctl.pcs = ((rd == 4'd15) && ctl.reg_w && !ctl.no_write) || branch;
    end

endmodule

// File: rtl/reg_list_scan.sv
// Lowest-set-bit index, its one-hot mask and population count of a register list.
module reg_list_scan #(
    parameter int N = 16
) (
    input  logic [N-1:0]             list,
    output logic [$clog2(N)-1:0]     idx,
    output logic [N-1:0]             clr,
    output logic [$clog2(N+1)-1:0]   cnt
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    // Scan from the top so the lowest set bit is the final writer of idx.
    always_comb begin
        idx = '0;
        cnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = list[i] ? IDX_W'(i) : idx;
            cnt = cnt + CNT_W'(list[i]);
        end
        clr = list & (~list + N'(1));
    end

endmodule

// File: rtl/seq_decoder.sv
// Registered, handshaked decode stage that expands LDM/STM into per-register micro-ops.
// Optional performance counters are built when DECODE_PERF_EN is defined.
module seq_decoder
    import decode_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OFS_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output ctl_t             ctl,
    output logic [3:0]       uop_reg,
    output logic [OFS_W-1:0] uop_offset,
    output logic [OFS_W-1:0] uop_wb_offset,
    output logic             uop_first,
    output logic             uop_last
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]      perf_instr,
    output logic [31:0]      perf_uop,
    output logic [31:0]      perf_stall
`endif
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]    n_q, n_d, k_q, k_d;
    logic                p_q, p_d, u_q, u_d, w_q, w_d, l_q, l_d;
    logic                out_valid_q, out_valid_d;
    ctl_t                ctl_q, ctl_d;
    logic [3:0]          uop_reg_q, uop_reg_d;
    logic [OFS_W-1:0]    ofs_q, ofs_d, wb_q, wb_d;
    logic                first_q, first_d, last_q, last_d;

    logic [1:0]          in_op;
    logic [5:0]          in_funct;
    logic [3:0]          in_rd;
    logic [NUM_REGS-1:0] in_list;
    logic                in_block, accept, advance;
    ctl_t                dec_ctl;
    logic [IDX_W-1:0]    in_idx, rem_idx;
    logic [NUM_REGS-1:0] in_clr, rem_clr;
    logic [CNT_W-1:0]    in_cnt, rem_cnt;
    logic                unused_bits;

    assign in_op       = instr[27:26];
    assign in_funct    = instr[25:20];
    assign in_rd       = instr[15:12];
    assign in_list     = instr[NUM_REGS-1:0];
    assign in_block    = (in_op == OP_BR) && !in_funct[5];
    assign unused_bits = ^{instr[31:28], instr[19:16]};

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign advance  = out_valid_q && out_ready;

    decoder u_decoder (
        .op    (in_op),
        .funct (in_funct),
        .rd    (in_rd),
        .ctl   (dec_ctl)
    );

    reg_list_scan #(.N(NUM_REGS)) u_in_scan (
        .list (in_list),
        .idx  (in_idx),
        .clr  (in_clr),
        .cnt  (in_cnt)
    );

    reg_list_scan #(.N(NUM_REGS)) u_rem_scan (
        .list (mask_q),
        .idx  (rem_idx),
        .clr  (rem_clr),
        .cnt  (rem_cnt)
    );

    // Byte offset of the k-th transfer; one formula covers IA, IB, DA and DB.
    function automatic logic [OFS_W-1:0] blk_ofs(input logic [CNT_W-1:0] k, input logic [CNT_W-1:0] n,
                                                 input logic p, input logic u);
        logic [OFS_W-1:0] k4;
        logic [OFS_W-1:0] n4;
        k4 = OFS_W'(k) << 2;
        n4 = OFS_W'(n) << 2;
        return k4 - (u ? {OFS_W{1'b0}} : n4) + ((p == u) ? OFS_W'(3'd4) : {OFS_W{1'b0}});
    endfunction

    function automatic logic [OFS_W-1:0] blk_wb(input logic [CNT_W-1:0] n, input logic u);
        logic [OFS_W-1:0] n4;
        n4 = OFS_W'(n) << 2;
        return u ? n4 : ({OFS_W{1'b0}} - n4);
    endfunction

    // Next-state and next-output selection for accept, expansion and hold.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        n_d         = n_q;
        k_d         = k_q;
        p_d         = p_q;
        u_d         = u_q;
        w_d         = w_q;
        l_d         = l_q;
        out_valid_d = out_valid_q;
        ctl_d       = ctl_q;
        uop_reg_d   = uop_reg_q;
        ofs_d       = ofs_q;
        wb_d        = wb_q;
        first_d     = first_q;
        last_d      = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    first_d     = 1'b1;
                    last_d      = 1'b1;
                    ofs_d       = '0;
                    wb_d        = '0;
                    uop_reg_d   = in_rd;
                    if (!in_block) begin
                        ctl_d = dec_ctl;
                    end else if (in_cnt == CNT_W'(0)) begin
                        ctl_d = nop_ctl();
                    end else begin
                        ctl_d     = blk_ctl(in_funct[0], 4'(in_idx) == 4'd15,
                                            in_funct[1] && (in_cnt == CNT_W'(1)));
                        uop_reg_d = 4'(in_idx);
                        ofs_d     = blk_ofs(CNT_W'(0), in_cnt, in_funct[4], in_funct[3]);
                        p_d       = in_funct[4];
                        u_d       = in_funct[3];
                        w_d       = in_funct[1];
                        l_d       = in_funct[0];
                        n_d       = in_cnt;
                        k_d       = CNT_W'(1);
                        mask_d    = in_list & ~in_clr;
                        if (in_cnt == CNT_W'(1)) begin
                            wb_d = blk_wb(in_cnt, in_funct[3]);
                        end else begin
                            last_d  = 1'b0;
                            state_d = EXPAND;
                        end
                    end
                end else if (advance) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            EXPAND: begin
                if (advance) begin
                    ctl_d     = blk_ctl(l_q, 4'(rem_idx) == 4'd15, w_q && (rem_cnt == CNT_W'(1)));
                    uop_reg_d = 4'(rem_idx);
                    ofs_d     = blk_ofs(k_q, n_q, p_q, u_q);
                    first_d   = 1'b0;
                    k_d       = k_q + CNT_W'(1);
                    mask_d    = mask_q & ~rem_clr;
                    if (rem_cnt == CNT_W'(1)) begin
                        last_d  = 1'b1;
                        wb_d    = blk_wb(n_q, u_q);
                        state_d = IDLE;
                    end else begin
                        last_d  = 1'b0;
                        wb_d    = '0;
                    end
                end else begin
                    state_d = EXPAND;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            n_q         <= '0;
            k_q         <= '0;
            p_q         <= 1'b0;
            u_q         <= 1'b0;
            w_q         <= 1'b0;
            l_q         <= 1'b0;
            out_valid_q <= 1'b0;
            ctl_q       <= '0;
            uop_reg_q   <= '0;
            ofs_q       <= '0;
            wb_q        <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            n_q         <= n_d;
            k_q         <= k_d;
            p_q         <= p_d;
            u_q         <= u_d;
            w_q         <= w_d;
            l_q         <= l_d;
            out_valid_q <= out_valid_d;
            ctl_q       <= ctl_d;
            uop_reg_q   <= uop_reg_d;
            ofs_q       <= ofs_d;
            wb_q        <= wb_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign ctl           = ctl_q;
    assign uop_reg       = uop_reg_q;
    assign uop_offset    = ofs_q;
    assign uop_wb_offset = wb_q;
    assign uop_first     = first_q;
    assign uop_last      = last_q;

`ifdef DECODE_PERF_EN
    logic [31:0] perf_instr_q, perf_instr_d;
    logic [31:0] perf_uop_q, perf_uop_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Event counters; they wrap naturally at 2^32.
    always_comb begin
        perf_instr_d = perf_instr_q + (accept ? 32'd1 : 32'd0);
        perf_uop_d   = perf_uop_q + (advance ? 32'd1 : 32'd0);
        perf_stall_d = perf_stall_q + ((out_valid_q && !out_ready) ? 32'd1 : 32'd0);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_instr_q <= 32'd0;
            perf_uop_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_instr_q <= perf_instr_d;
            perf_uop_q   <= perf_uop_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_instr = perf_instr_q;
    assign perf_uop   = perf_uop_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_seq_decoder.sv
// Directed scoreboard bench for seq_decoder.
module tb_seq_decoder;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr;
    ctl_t        ctl;
    logic [3:0]  uop_reg;
    logic [7:0]  uop_offset, uop_wb_offset;
    logic        uop_first, uop_last;
`ifdef DECODE_PERF_EN
    logic [31:0] perf_instr, perf_uop, perf_stall;
    logic [31:0] stall0, uop0;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] r;
        logic [7:0] ofs;
        logic [7:0] wb;
        logic       first;
        logic       last;
        logic [2:0] alu;
        logic       reg_w;
        logic       mem_w;
        logic       pcs;
        logic       no_write;
        logic       bw;
        logic [1:0] res;
    } exp_t;

    exp_t q[$];

    seq_decoder #(.NUM_REGS(16), .OFS_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ctl           (ctl),
        .uop_reg       (uop_reg),
        .uop_offset    (uop_offset),
        .uop_wb_offset (uop_wb_offset),
        .uop_first     (uop_first),
        .uop_last      (uop_last)
`ifdef DECODE_PERF_EN
        ,
        .perf_instr    (perf_instr),
        .perf_uop      (perf_uop),
        .perf_stall    (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_single(input logic [3:0] r, input logic [2:0] alu, input logic reg_w,
                               input logic mem_w, input logic pcs, input logic [1:0] res);
        exp_t e;
        e.r = r; e.ofs = 8'h00; e.wb = 8'h00; e.first = 1'b1; e.last = 1'b1;
        e.alu = alu; e.reg_w = reg_w; e.mem_w = mem_w; e.pcs = pcs;
        e.no_write = 1'b0; e.bw = 1'b0; e.res = res;
        q.push_back(e);
    endtask

    // Reference expansion of a block transfer, straight from the offset rules.
    task automatic push_block(input logic [31:0] ins);
        exp_t        e;
        logic [15:0] list;
        int          n, k, ofs, wbv;
        logic        p, u, w, l;
        list = ins[15:0];
        n = $countones(list);
        p = ins[24]; u = ins[23]; w = ins[21]; l = ins[20];
        k = 0;
        if (n == 0) begin
            e.r = ins[15:12]; e.ofs = 8'h00; e.wb = 8'h00; e.first = 1'b1; e.last = 1'b1;
            e.alu = 3'b000; e.reg_w = 1'b0; e.mem_w = 1'b0; e.pcs = 1'b0;
            e.no_write = 1'b1; e.bw = 1'b0; e.res = 2'b00;
            q.push_back(e);
        end
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                ofs = 4 * k + (u ? 0 : -4 * n) + ((p == u) ? 4 : 0);
                wbv = u ? 4 * n : -4 * n;
                e.r = 4'(i);
                e.ofs = ofs[7:0];
                e.first = (k == 0);
                e.last = (k == n - 1);
                e.bw = w && e.last;
                e.wb = e.last ? wbv[7:0] : 8'h00;
                e.alu = 3'b000; e.reg_w = l; e.mem_w = !l; e.pcs = l && (i == 15);
                e.no_write = 1'b0; e.res = l ? 2'b10 : 2'b00;
                q.push_back(e);
                k++;
            end
        end
    endtask

    task automatic send(input logic [31:0] ins);
        int cyc;
        cyc = 0;
        instr = ins;
        in_valid = 1'b1;
        while (!in_ready && cyc < 20) begin
            step();
            cyc++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        instr = 32'h0;
    endtask

    task automatic drain(input int max_cyc);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (q.size() > 0 && cyc < max_cyc) begin
            if (out_valid && out_ready) begin
                e = q.pop_front();
                chk("uop_reg", 32'(uop_reg), 32'(e.r));
                chk("uop_offset", 32'(uop_offset), 32'(e.ofs));
                chk("uop_first", 32'(uop_first), 32'(e.first));
                chk("uop_last", 32'(uop_last), 32'(e.last));
                chk("alu_ctl", 32'(ctl.alu_ctl), 32'(e.alu));
                chk("reg_w", 32'(ctl.reg_w), 32'(e.reg_w));
                chk("mem_w", 32'(ctl.mem_w), 32'(e.mem_w));
                chk("pcs", 32'(ctl.pcs), 32'(e.pcs));
                chk("no_write", 32'(ctl.no_write), 32'(e.no_write));
                chk("base_reg_write", 32'(ctl.base_reg_write), 32'(e.bw));
                chk("result_src", 32'(ctl.result_src), 32'(e.res));
                if (e.bw) chk("wb_offset", 32'(uop_wb_offset), 32'(e.wb));
                if (!e.last) chk("in_ready_expand", 32'(in_ready), 32'd0);
            end
            step();
            cyc++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
        chk("no_extra_uop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        instr = 32'h0;
        out_ready = 1'b1;

        step();
        chk("rst_out_valid0", 32'(out_valid), 32'd0);
        step();
        chk("rst_out_valid1", 32'(out_valid), 32'd0);
        chk("rst_ctl", 32'(ctl), 32'd0);
        chk("rst_uop_reg", 32'(uop_reg), 32'd0);
        chk("rst_offset", 32'(uop_offset), 32'd0);
        chk("rst_wb", 32'(uop_wb_offset), 32'd0);
        chk("rst_first_last", {30'd0, uop_first, uop_last}, 32'd0);
        reset = 1'b0;
        step();
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        push_single(4'd1, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00);
        send(32'hE0821003);
        drain(10);
        push_single(4'd2, 3'b000, 1'b1, 1'b0, 1'b0, 2'b10);
        send(32'hE5932004);
        drain(10);
        push_single(4'd4, 3'b001, 1'b1, 1'b0, 1'b0, 2'b00);
        send(32'hE2454001);
        drain(10);
        push_single(4'd0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00);
        send(32'hEA000000);
        drain(10);

        push_block(32'hE8B0800A);
        send(32'hE8B0800A);
        drain(20);
        push_block(32'hE92D0030);
        send(32'hE92D0030);
        drain(20);
        push_block(32'hE8800004);
        send(32'hE8800004);
        drain(20);

`ifdef DECODE_PERF_EN
        stall0 = perf_stall;
        uop0 = perf_uop;
`endif
        push_block(32'hE8B0800A);
        send(32'hE8B0800A);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_reg", 32'(uop_reg), 32'd1);
            chk("hold_offset", 32'(uop_offset), 32'd0);
            chk("hold_first", 32'(uop_first), 32'd1);
            step();
        end
        out_ready = 1'b1;
        drain(20);
`ifdef DECODE_PERF_EN
        chk("perf_stall", perf_stall - stall0, 32'd3);
        chk("perf_uop", perf_uop - uop0, 32'd3);
`endif

        send(32'hE8B0800A);
        chk("mid_first_reg", 32'(uop_reg), 32'd1);
        chk("mid_first_valid", 32'(out_valid), 32'd1);
        step();
        chk("mid_second_reg", 32'(uop_reg), 32'd3);
        reset = 1'b1;
        step();
        chk("mid_reset_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        step();
        chk("post_reset_valid", 32'(out_valid), 32'd0);
        chk("post_reset_ready", 32'(in_ready), 32'd1);
        step();
        chk("post_reset_quiet", 32'(out_valid), 32'd0);

        push_block(32'hE8900000);
        send(32'hE8900000);
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
